// File: rtl/multi_buffer_ram_pkg.sv
// Shared types and constants for the multi_buffer_ram buffer ring.
package multi_buffer_ram_pkg;

    // Writer side state: filling a free buffer, or blocked on a full ring.
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } wr_state_e;

    // Width of the optional dropped-beat counter.
    localparam int DROP_CNT_W = 32;

endpackage

// File: rtl/mbuf_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// 1-cycle read. The read register holds its value when no read is issued.
// The ring controller never reads and writes the same word in one cycle,
// so no collision handling is needed here.
module mbuf_sdp_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Select new read data on a read, otherwise hold the last word.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem[raddr_i];
        end
    end

    // Read output register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/multi_buffer_ram.sv
// N-way capture buffer ring. A streaming writer fills buffers in rotation;
// the consumer reads the oldest completed buffer and releases it explicitly.
// Optional feature: define MULTI_BUFFER_RAM_DROP_CNT_EN to add drop_cnt_o,
// a saturating count of beats discarded while the ring is full.
module multi_buffer_ram
    import multi_buffer_ram_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int SAMPLES_PER_BUF = 256,
    parameter int NUM_BUFS        = 4,
    parameter int DROP_WHEN_FULL  = 0,
    parameter int ADDR_WIDTH      = $clog2(SAMPLES_PER_BUF),
    parameter int BUF_W           = $clog2(NUM_BUFS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_data_valid_o,
    input  logic                  rd_release_i,
    output logic [BUF_W-1:0]      wr_buf_o,
    output logic [BUF_W-1:0]      head_buf_o,
    output logic [BUF_W:0]        fill_cnt_o,
    output logic                  buf_ready_pulse_o,
    output logic [BUF_W-1:0]      buf_ready_id_o,
    output logic                  overflow_o
`ifdef MULTI_BUFFER_RAM_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
`endif
);

    localparam bit                    DROP_EN   = (DROP_WHEN_FULL != 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLES_PER_BUF - 1);
    localparam logic [BUF_W:0]        LAST_FILL = (BUF_W + 1)'(NUM_BUFS - 1);

    wr_state_e             state_q, state_d;
    logic                  run_q, run_d;
    logic [BUF_W-1:0]      wr_buf_q, wr_buf_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [BUF_W-1:0]      head_q, head_d;
    logic [BUF_W:0]        fill_q, fill_d;
    logic                  pulse_q, pulse_d;
    logic [BUF_W-1:0]      pulse_id_q, pulse_id_d;
    logic                  ovf_q, ovf_d;
    logic                  rd_vld_q, rd_vld_d;

    logic accept, wr_en, complete, drop, rel_ok, rd_fire;

    // Ready is held low until the first edge after reset release.
    assign in_ready_o = run_q && ((state_q == FILL) || DROP_EN);
    assign accept     = in_valid_i && in_ready_o;
    assign wr_en      = accept && (state_q == FILL);
    assign complete   = wr_en && (wr_addr_q == LAST_ADDR);
    assign drop       = accept && (state_q == FULL) && DROP_EN;
    assign rel_ok     = rd_release_i && (fill_q != '0);
    assign rd_fire    = rd_en_i && (fill_q != '0);

    // Next-state for pointers, occupancy, write FSM and registered strobes.
    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        wr_buf_d   = wr_buf_q;
        wr_addr_d  = wr_addr_q;
        head_d     = head_q;
        fill_d     = fill_q;
        pulse_d    = complete;
        pulse_id_d = complete ? wr_buf_q : '0;
        ovf_d      = drop;
        rd_vld_d   = rd_fire;

        // Address wraps naturally since buffer size is a power of two.
        if (wr_en) begin
            wr_addr_d = wr_addr_q + 1'b1;
        end
        if (complete) begin
            wr_buf_d = wr_buf_q + 1'b1;
        end
        if (rel_ok) begin
            head_d = head_q + 1'b1;
        end

        case ({complete, rel_ok})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase

        // On release out of FULL, wr_buf already equals the freed head and
        // wr_addr is still 0, so writing restarts cleanly in that buffer.
        case (state_q)
            FILL: if (complete && !rel_ok && (fill_q == LAST_FILL)) state_d = FULL;
            FULL: if (rel_ok) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= FILL;
            run_q      <= 1'b0;
            wr_buf_q   <= '0;
            wr_addr_q  <= '0;
            head_q     <= '0;
            fill_q     <= '0;
            pulse_q    <= 1'b0;
            pulse_id_q <= '0;
            ovf_q      <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            wr_buf_q   <= wr_buf_d;
            wr_addr_q  <= wr_addr_d;
            head_q     <= head_d;
            fill_q     <= fill_d;
            pulse_q    <= pulse_d;
            pulse_id_q <= pulse_id_d;
            ovf_q      <= ovf_d;
            rd_vld_q   <= rd_vld_d;
        end
    end

    mbuf_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (BUF_W + ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_en),
        .waddr_i ({wr_buf_q, wr_addr_q}),
        .wdata_i (in_data_i),
        .re_i    (rd_fire),
        .raddr_i ({head_q, rd_addr_i}),
        .rdata_o (rd_data_o)
    );

    assign rd_data_valid_o   = rd_vld_q;
    assign wr_buf_o          = wr_buf_q;
    assign head_buf_o        = head_q;
    assign fill_cnt_o        = fill_q;
    assign buf_ready_pulse_o = pulse_q;
    assign buf_ready_id_o    = pulse_id_q;
    assign overflow_o        = ovf_q;

`ifdef MULTI_BUFFER_RAM_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Saturating count of discarded beats.
    always_comb begin
        drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    // Drop counter register, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_multi_buffer_ram.sv
// Bench for multi_buffer_ram: a stall-mode and a drop-mode instance driven
// in lockstep, with a reference model feeding expected-pulse and
// expected-read queues that a negedge monitor drains.
module tb_multi_buffer_ram;

    localparam int DW  = 16;
    localparam int SPB = 16;
    localparam int NB  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          rd_en = 1'b0;
    logic [3:0]    rd_addr = '0;
    logic          rd_release = 1'b0;

    logic          s_ready, s_rdv, s_pulse, s_ovf;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_wbuf, s_head, s_id;
    logic [2:0]    s_fill;
    logic          d_ready, d_rdv, d_pulse, d_ovf;
    logic [DW-1:0] d_rdata;
    logic [1:0]    d_wbuf, d_head, d_id;
    logic [2:0]    d_fill;
`ifdef MULTI_BUFFER_RAM_DROP_CNT_EN
    logic [31:0]   s_drop_cnt, d_drop_cnt;
`endif

    always #5 clk = ~clk;

    multi_buffer_ram #(
        .DATA_WIDTH(DW), .SAMPLES_PER_BUF(SPB), .NUM_BUFS(NB), .DROP_WHEN_FULL(0)
    ) dut_stall (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(s_ready), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(s_rdata), .rd_data_valid_o(s_rdv), .rd_release_i(rd_release),
        .wr_buf_o(s_wbuf), .head_buf_o(s_head), .fill_cnt_o(s_fill),
        .buf_ready_pulse_o(s_pulse), .buf_ready_id_o(s_id), .overflow_o(s_ovf)
`ifdef MULTI_BUFFER_RAM_DROP_CNT_EN
        , .drop_cnt_o(s_drop_cnt)
`endif
    );

    multi_buffer_ram #(
        .DATA_WIDTH(DW), .SAMPLES_PER_BUF(SPB), .NUM_BUFS(NB), .DROP_WHEN_FULL(1)
    ) dut_drop (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(d_ready), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(d_rdata), .rd_data_valid_o(d_rdv), .rd_release_i(rd_release),
        .wr_buf_o(d_wbuf), .head_buf_o(d_head), .fill_cnt_o(d_fill),
        .buf_ready_pulse_o(d_pulse), .buf_ready_id_o(d_id), .overflow_o(d_ovf)
`ifdef MULTI_BUFFER_RAM_DROP_CNT_EN
        , .drop_cnt_o(d_drop_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int            m_wbuf = 0, m_addr = 0, m_head = 0, m_fill = 0;
    int            exp_ovf = 0, s_ovf_seen = 0, d_ovf_seen = 0;
    logic [DW-1:0] mmem [NB*SPB];
    logic [1:0]    q_pulse_s[$], q_pulse_d[$];
    logic [DW-1:0] q_rd_s[$], q_rd_d[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model applies the effect of the coming edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic re,
                       input logic [3:0] ra, input logic rel);
        bit full, acc, cmp, relok;
        @(negedge clk);
        in_valid = v; in_data = d; rd_en = re; rd_addr = ra; rd_release = rel;
        full  = (m_fill == NB);
        acc   = v && !full;
        cmp   = acc && (m_addr == SPB - 1);
        relok = rel && (m_fill > 0);
        if (re && m_fill > 0) begin
            q_rd_s.push_back(mmem[m_head*SPB + int'(ra)]);
            q_rd_d.push_back(mmem[m_head*SPB + int'(ra)]);
        end
        if (v && full) exp_ovf++;
        if (acc) begin
            mmem[m_wbuf*SPB + m_addr] = d;
            m_addr = (m_addr + 1) % SPB;
        end
        if (cmp) begin
            q_pulse_s.push_back(2'(m_wbuf));
            q_pulse_d.push_back(2'(m_wbuf));
            m_wbuf = (m_wbuf + 1) % NB;
            m_fill++;
        end
        if (relok) begin
            m_head = (m_head + 1) % NB;
            m_fill--;
        end
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic write_buf(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, base + DW'(i), 1'b0, 4'd0, 1'b0);
    endtask

    task automatic read_buf();
        for (int i = 0; i < SPB; i++) cyc(1'b0, '0, 1'b1, 4'(i), 1'b0);
        idle();
        idle();
    endtask

    task automatic chk_status(input string tag, input int fill, input int head, input int wbuf);
        chk({tag, "_s_fill"}, 32'(s_fill), 32'(fill));
        chk({tag, "_s_head"}, 32'(s_head), 32'(head));
        chk({tag, "_s_wbuf"}, 32'(s_wbuf), 32'(wbuf));
        chk({tag, "_d_fill"}, 32'(d_fill), 32'(fill));
        chk({tag, "_d_head"}, 32'(d_head), 32'(head));
        chk({tag, "_d_wbuf"}, 32'(d_wbuf), 32'(wbuf));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_d_ready"}, 32'(d_ready), 0);
        chk({tag, "_s_rdv"},   32'(s_rdv), 0);
        chk({tag, "_s_rdata"}, 32'(s_rdata), 0);
        chk({tag, "_s_pulse"}, 32'(s_pulse), 0);
        chk({tag, "_s_id"},    32'(s_id), 0);
        chk({tag, "_d_ovf"},   32'(d_ovf), 0);
        chk_status(tag, 0, 0, 0);
    endtask

    task automatic model_reset();
        m_wbuf = 0; m_addr = 0; m_head = 0; m_fill = 0;
    endtask

    // Output monitor: drains expected pulses and read data.
    always @(negedge clk) begin
        if (s_pulse) begin
            if (q_pulse_s.size() == 0) chk("s_pulse_extra", 1, 0);
            else chk("s_pulse_id", 32'(s_id), 32'(q_pulse_s.pop_front()));
        end
        if (d_pulse) begin
            if (q_pulse_d.size() == 0) chk("d_pulse_extra", 1, 0);
            else chk("d_pulse_id", 32'(d_id), 32'(q_pulse_d.pop_front()));
        end
        if (s_rdv) begin
            if (q_rd_s.size() == 0) chk("s_rd_extra", 1, 0);
            else chk("s_rd_data", 32'(s_rdata), 32'(q_rd_s.pop_front()));
        end
        if (d_rdv) begin
            if (q_rd_d.size() == 0) chk("d_rd_extra", 1, 0);
            else chk("d_rd_data", 32'(d_rdata), 32'(q_rd_d.pop_front()));
        end
        if (s_ovf) s_ovf_seen++;
        if (d_ovf) d_ovf_seen++;
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b0;
        #1;
        chk("rst_rel_ready_low", 32'(s_ready), 0);
        @(negedge clk);
        chk("rst_rel_s_ready", 32'(s_ready), 1);
        chk("rst_rel_d_ready", 32'(d_ready), 1);

        // First buffer and read-back with latency check
        write_buf(16'h1000, SPB);
        idle();
        chk_status("buf0", 1, 0, 1);
        cyc(1'b0, '0, 1'b1, 4'd0, 1'b0);
        cyc(1'b0, '0, 1'b1, 4'd1, 1'b0);
        chk("rd_latency", 32'(s_rdv), 1);
        chk("rd_first", 32'(s_rdata), 32'h1000);
        for (int i = 2; i < SPB; i++) cyc(1'b0, '0, 1'b1, 4'(i), 1'b0);
        idle();
        idle();

        // Fill the ring
        write_buf(16'h2000, 3 * SPB);
        idle();
        chk_status("full", 4, 0, 0);
        chk("full_s_ready", 32'(s_ready), 0);
        chk("full_d_ready", 32'(d_ready), 1);

        // Extra beats while full: stall instance blocks, drop instance discards
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'hDEAD, 1'b0, 4'd0, 1'b0);
        idle();
        idle();
        chk("ovf_pulses_drop", 32'(d_ovf_seen), 32'(exp_ovf));
        chk("ovf_pulses_stall", 32'(s_ovf_seen), 0);
        chk("full_hold_s_fill", 32'(s_fill), 4);
`ifdef MULTI_BUFFER_RAM_DROP_CNT_EN
        chk("drop_cnt_drop", d_drop_cnt, 5);
        chk("drop_cnt_stall", s_drop_cnt, 0);
`endif
        read_buf();

        // Single release frees buffer 0 for writing
        cyc(1'b0, '0, 1'b0, 4'd0, 1'b1);
        idle();
        chk_status("rel1", 3, 1, 0);
        chk("rel1_s_ready", 32'(s_ready), 1);
        write_buf(16'h3000, SPB);
        idle();
        chk_status("refill", 4, 1, 1);
        chk("refill_s_ready", 32'(s_ready), 0);

        // Completion and release in the same cycle with fill=2
        cyc(1'b0, '0, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, '0, 1'b0, 4'd0, 1'b1);
        idle();
        chk_status("two_rel", 2, 3, 1);
        write_buf(16'h5000, SPB - 1);
        cyc(1'b1, 16'h500F, 1'b0, 4'd0, 1'b1);
        idle();
        chk_status("cmp_rel", 2, 0, 2);
        chk("cmp_rel_s_ready", 32'(s_ready), 1);
        read_buf();

        // Release and read on an empty ring
        cyc(1'b0, '0, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, '0, 1'b0, 4'd0, 1'b1);
        idle();
        chk_status("empty", 0, 2, 2);
        cyc(1'b0, '0, 1'b1, 4'd5, 1'b1);
        idle();
        chk("empty_rdv", 32'(s_rdv), 0);
        chk("empty_rdata_hold", 32'(s_rdata), 32'h300F);
        chk_status("empty_rel", 0, 2, 2);

        // Reset in the middle of a fill
        write_buf(16'h6000, 7);
        @(negedge clk);
        in_valid = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        write_buf(16'h7000, SPB);
        idle();
        chk_status("post_rst", 1, 0, 1);
        read_buf();

        chk("pulse_q_s_empty", 32'(q_pulse_s.size()), 0);
        chk("pulse_q_d_empty", 32'(q_pulse_d.size()), 0);
        chk("rd_q_s_empty", 32'(q_rd_s.size()), 0);
        chk("rd_q_d_empty", 32'(q_rd_d.size()), 0);
        chk("ovf_total", 32'(d_ovf_seen), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_buffer_ram.md
# multi_buffer_ram

Parametrised N-way buffer ring for sample capture: a streaming writer fills fixed-size buffers in rotation while a block consumer reads the oldest completed buffer at random addresses and explicitly releases it. Generalises ping-pong buffering to NUM_BUFS buffers with consumer-driven release, selectable stall-or-drop overflow policy and fill-level reporting. Sits between the sample front end and the block-processing engine.

## Interface
- DATA_WIDTH, 16: sample width in bits.
- SAMPLES_PER_BUF, 256: words per buffer; power of two, at least 4.
- NUM_BUFS, 4: buffers in the ring; power of two, at least 2.
- DROP_WHEN_FULL, 0: 0 stalls the writer when the ring is full; 1 keeps accepting beats and discards them.
- ADDR_WIDTH, $clog2(SAMPLES_PER_BUF): derived.
- BUF_W, $clog2(NUM_BUFS): derived.
- clk_i  in  1  Sole clock.
- rst_i  in  1  Reset; asynchronous, active-high.
- in_valid_i  in  1  Write beat valid.
- in_data_i  in  DATA_WIDTH  Write data.
- in_ready_o  out  1  Writer may transfer.
- rd_en_i  in  1  Read request on the head buffer.
- rd_addr_i  in  ADDR_WIDTH  Word address within the head buffer.
- rd_data_o  out  DATA_WIDTH  Read data.
- rd_data_valid_o  out  1  rd_data_o valid.
- rd_release_i  in  1  Consumer has finished with the head buffer.
- wr_buf_o  out  BUF_W  Buffer currently being filled.
- head_buf_o  out  BUF_W  Oldest filled buffer (read target).
- fill_cnt_o  out  BUF_W+1  Number of filled, unreleased buffers.
- buf_ready_pulse_o  out  1  One-cycle pulse when a buffer completes.
- buf_ready_id_o  out  BUF_W  Index of the completed buffer.
- overflow_o  out  1  One-cycle pulse per dropped beat; held low when DROP_WHEN_FULL=0.

## Operation
- Storage: one simple dual-port memory of NUM_BUFS*SAMPLES_PER_BUF words addressed as {buf, addr}. Contents are not cleared by reset.
- A beat is accepted when in_valid_i && in_ready_o. It is written to {wr_buf, wr_addr}, then wr_addr increments.
- Completion: the beat at wr_addr = SAMPLES_PER_BUF-1 is accepted. wr_addr wraps to 0, wr_buf advances mod NUM_BUFS, fill_cnt increments, and a pulse is issued with id = the old wr_buf.
- Write FSM states:
  - FILL: in_ready_o=1.
  - FULL: the ring is full. Entered when completion makes fill_cnt = NUM_BUFS, so wr_buf equals head_buf.
- FULL with DROP_WHEN_FULL=0: in_ready_o=0.
- FULL with DROP_WHEN_FULL=1: in_ready_o=1. Each accepted beat is discarded, overflow_o pulses, and wr_addr does not move.
- FULL → FILL: on rd_release_i. The freed head becomes the write buffer, starting at address 0.
- Release: when fill_cnt>0, head_buf advances mod NUM_BUFS and fill_cnt decrements. Release with fill_cnt=0 is ignored.
- Completion and release in the same cycle: fill_cnt is unchanged, head advances, wr_buf advances, and the FSM stays in FILL.
- Read: rd_data_valid_o = registered (rd_en_i && fill_cnt>0). Reads on an empty ring return valid=0 and rd_data_o holds its last value.
- Read and release in the same cycle: the read uses the pre-release head.
- fill_cnt ranges 0..NUM_BUFS. The write buffer is never counted as filled except in FULL.

## Timing
- Reset values: in_ready_o=0 while rst_i is high, 1 from the first clk_i edge after deassertion. All other outputs are 0. FSM=FILL, all pointers 0.
- Reset asserted mid-fill or mid-read: the partial buffer and all filled buffers are abandoned, with no pulse issued.
- buf_ready_pulse_o, buf_ready_id_o, fill_cnt_o and wr_buf_o update on the edge that accepts the last word, and are visible the next cycle.
- Read latency is 1 cycle, and one read can be accepted every cycle.
- Release takes effect on the next edge: head_buf_o and fill_cnt_o are updated the next cycle.
- Stall mode: in_ready_o rises the cycle after the releasing edge. No beat is lost or duplicated across a stall.
- overflow_o is registered and aligned one cycle after the dropped beat.

## Configuration
- MULTI_BUFFER_RAM_DROP_CNT_EN, when defined:
  - Adds output drop_cnt_o (32 bits), which counts dropped beats.
  - The counter saturates at 0xFFFF_FFFF and is cleared by rst_i only.
- Without the macro: the port and counter are absent, and overflow_o is unchanged.

## Structure
- Package multi_buffer_ram_pkg holds:
  - the wr_state_e enum (FILL, FULL);
  - the DROP_CNT_W=32 constant.
- Sub-module mbuf_sdp_ram: generic simple dual-port RAM with a registered 1-cycle read and write-first-free behaviour (no same-address collision possible by construction, since the write buffer is never the head while fill_cnt>0 outside FULL).

## Test plan
Bench configuration for all scenarios: NUM_BUFS=4, SAMPLES_PER_BUF=16, DATA_WIDTH=16.
- Reset: write 16 values 0x1000..0x100F with valid=1 every cycle.
  - One pulse with id=0; fill_cnt_o=1; wr_buf_o=1.
  - Reading addresses 0..15 returns 0x1000..0x100F, each 1 cycle after its rd_en.
- Fill 4 buffers without release, DROP_WHEN_FULL=0 → after the 64th beat, in_ready_o=0 and fill_cnt_o=4. One release → head_buf_o=1, fill_cnt_o=3, in_ready_o=1, writes resume into buffer 0.
- DROP_WHEN_FULL=1 and ring full: drive 5 extra beats → 5 overflow_o pulses, memory is unchanged, and drop_cnt_o=5 with the macro defined.
- Last-word completion and rd_release_i in the same cycle with fill_cnt=2 → fill_cnt stays 2, head and wr_buf both advance, one pulse.
- rd_release_i and rd_en_i with fill_cnt=0 → fill_cnt stays 0, rd_data_valid_o=0.
- Assert rst_i after 7 beats of buffer 0 → all outputs 0 immediately. After deassertion, 16 new beats produce a pulse with id=0 and the new data reads back.
